// File: rtl/pixel_scan_if.sv
// Pixel sample stream from the scan sequencer to generate_ray, with the shared stall.
// The master drives the sample tuple; the slave (ray pipeline) drives stall.
interface pixel_scan_if #(
  parameter int COORD_W = 10,
  parameter int SPP_W   = 3
) ();

  logic [COORD_W-1:0] pixel_x;
  logic [COORD_W-1:0] pixel_y;
  logic [SPP_W-1:0]   sample_idx;
  logic               pixel_valid;
  logic               last_sample;
  logic               stall;

  modport master (
    output pixel_x,
    output pixel_y,
    output sample_idx,
    output pixel_valid,
    output last_sample,
    input  stall
  );

  modport slave (
    input  pixel_x,
    input  pixel_y,
    input  sample_idx,
    input  pixel_valid,
    input  last_sample,
    output stall
  );

endinterface

// File: rtl/pixel_scan_sequencer.sv
// Raster-order (x, y, sample) generator for one frame, followed by a stall-aware
// drain of the downstream ray pipeline and a one-cycle frame_done pulse.
module pixel_scan_sequencer #(
  parameter int PIXEL_WIDTH  = 800,
  parameter int PIXEL_HEIGHT = 600,
  parameter int SPP          = 4,
  parameter int PIPE_LATENCY = 4,
  parameter int COORD_W      = 10,
  parameter int SPP_W        = $clog2(SPP + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic              abort,
  pixel_scan_if.master      pix,
  output logic              frame_busy,
  output logic              frame_done
);

  localparam int CNT_W = $clog2(PIPE_LATENCY + 1);

  localparam logic [COORD_W-1:0] X_MAX     = COORD_W'(PIXEL_WIDTH - 1);
  localparam logic [COORD_W-1:0] Y_MAX     = COORD_W'(PIXEL_HEIGHT - 1);
  localparam logic [SPP_W-1:0]   S_MAX     = SPP_W'(SPP - 1);
  localparam logic [COORD_W-1:0] COORD_ZERO = COORD_W'(0);
  localparam logic [SPP_W-1:0]   S_ZERO    = SPP_W'(0);
  localparam logic [CNT_W-1:0]   CNT_INIT  = CNT_W'(PIPE_LATENCY);
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]   CNT_ZERO  = CNT_W'(0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic [COORD_W-1:0] x_r;
  logic [COORD_W-1:0] y_r;
  logic [SPP_W-1:0]   s_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [COORD_W-1:0] x_nxt_s;
  logic [COORD_W-1:0] y_nxt_s;
  logic [SPP_W-1:0]   s_nxt_s;
  logic [CNT_W-1:0]   cnt_nxt_s;
  logic               valid_r;
  logic               busy_r;
  logic               done_r;
  logic               accept_s;
  logic               at_last_s;

  assign accept_s  = valid_r & ~pix.stall;
  assign at_last_s = (x_r == X_MAX) & (y_r == Y_MAX) & (s_r == S_MAX);

  // Next-state and next-counter logic; abort overrides every state.
  always_comb begin
    state_nxt_s = state_r;
    x_nxt_s     = x_r;
    y_nxt_s     = y_r;
    s_nxt_s     = s_r;
    cnt_nxt_s   = cnt_r;
    if (abort) begin
      state_nxt_s = ST_IDLE;
      x_nxt_s     = COORD_ZERO;
      y_nxt_s     = COORD_ZERO;
      s_nxt_s     = S_ZERO;
      cnt_nxt_s   = CNT_ZERO;
    end else begin
      case (state_r)
        ST_IDLE: begin
          x_nxt_s   = COORD_ZERO;
          y_nxt_s   = COORD_ZERO;
          s_nxt_s   = S_ZERO;
          cnt_nxt_s = CNT_ZERO;
          if (frame_start) begin
            state_nxt_s = ST_SCAN;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_SCAN: begin
          if (accept_s) begin
            // The final tuple stays on the bus through the drain, so no wrap here.
            if (at_last_s) begin
              state_nxt_s = ST_DRAIN;
              cnt_nxt_s   = CNT_INIT;
            end else if (s_r != S_MAX) begin
              s_nxt_s = s_r + 1'b1;
            end else begin
              s_nxt_s = S_ZERO;
              if (x_r != X_MAX) begin
                x_nxt_s = x_r + 1'b1;
              end else begin
                x_nxt_s = COORD_ZERO;
                y_nxt_s = y_r + 1'b1;
              end
            end
          end else begin
            state_nxt_s = ST_SCAN;
          end
        end
        ST_DRAIN: begin
          if (pix.stall) begin
            cnt_nxt_s = cnt_r;
          end else if (cnt_r == CNT_ONE) begin
            state_nxt_s = ST_DONE;
            cnt_nxt_s   = CNT_ZERO;
          end else begin
            cnt_nxt_s = cnt_r - 1'b1;
          end
        end
        ST_DONE: begin
          state_nxt_s = ST_IDLE;
          x_nxt_s     = COORD_ZERO;
          y_nxt_s     = COORD_ZERO;
          s_nxt_s     = S_ZERO;
          cnt_nxt_s   = CNT_ZERO;
        end
        default: begin
          state_nxt_s = ST_IDLE;
          x_nxt_s     = COORD_ZERO;
          y_nxt_s     = COORD_ZERO;
          s_nxt_s     = S_ZERO;
          cnt_nxt_s   = CNT_ZERO;
        end
      endcase
    end
  end

  // State, counters and status flags; flags are precomputed from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      x_r     <= COORD_ZERO;
      y_r     <= COORD_ZERO;
      s_r     <= S_ZERO;
      cnt_r   <= CNT_ZERO;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      x_r     <= x_nxt_s;
      y_r     <= y_nxt_s;
      s_r     <= s_nxt_s;
      cnt_r   <= cnt_nxt_s;
      valid_r <= (state_nxt_s == ST_SCAN);
      busy_r  <= (state_nxt_s != ST_IDLE);
      done_r  <= (state_nxt_s == ST_DONE);
    end
  end

  assign pix.pixel_x     = x_r;
  assign pix.pixel_y     = y_r;
  assign pix.sample_idx  = s_r;
  assign pix.pixel_valid = valid_r;
  assign pix.last_sample = valid_r & at_last_s;
  assign frame_busy      = busy_r;
  assign frame_done      = done_r;

endmodule

// File: tb/tb_pixel_scan_sequencer.sv
// Directed bench for pixel_scan_sequencer with a 4x3 frame, 2 samples per pixel
// and a 4-cycle pipeline: a vector table for short sequences plus whole-frame runs.
module tb_pixel_scan_sequencer;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int SP = 2;
  localparam int L  = 4;
  localparam int CW = 10;
  localparam int SW = 2;
  localparam int N  = W * H * SP;

  logic clk = 1'b0;
  logic rst;
  logic frame_start;
  logic abort;
  logic frame_busy;
  logic frame_done;

  int n_cmp = 0;
  int n_bad = 0;

  pixel_scan_if #(.COORD_W(CW), .SPP_W(SW)) pif ();

  pixel_scan_sequencer #(
    .PIXEL_WIDTH(W), .PIXEL_HEIGHT(H), .SPP(SP), .PIPE_LATENCY(L),
    .COORD_W(CW), .SPP_W(SW)
  ) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .abort(abort),
    .pix(pif), .frame_busy(frame_busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic fs; logic ab; logic st;
    logic ev; int ex; int ey; int es; logic el; logic eb; logic ed;
  } vec_t;

  vec_t tbl [10];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic ev, input int ex, input int ey,
                     input int es, input logic el, input logic eb, input logic ed);
    n_cmp++;
    if (pif.pixel_valid !== ev || pif.pixel_x !== CW'(ex) || pif.pixel_y !== CW'(ey) ||
        pif.sample_idx !== SW'(es) || pif.last_sample !== el ||
        frame_busy !== eb || frame_done !== ed) begin
      n_bad++;
      $display("FAIL %s: got v%0b (%0d,%0d,%0d) last%0b busy%0b done%0b, expected v%0b (%0d,%0d,%0d) last%0b busy%0b done%0b",
               name, pif.pixel_valid, pif.pixel_x, pif.pixel_y, pif.sample_idx,
               pif.last_sample, frame_busy, frame_done, ev, ex, ey, es, el, eb, ed);
    end
  endtask

  task automatic chk_flags(input string name, input logic ev, input logic eb, input logic ed);
    n_cmp++;
    if (pif.pixel_valid !== ev || frame_busy !== eb || frame_done !== ed) begin
      n_bad++;
      $display("FAIL %s: got v%0b busy%0b done%0b, expected v%0b busy%0b done%0b",
               name, pif.pixel_valid, frame_busy, frame_done, ev, eb, ed);
    end
  endtask

  // One frame from IDLE: optional scan stall, drain stall, ignored restart, or abort.
  task automatic run_frame(input string tag, input int stall_k, input int stall_n,
                           input int drain_stall, input int fs_k, input int abort_k);
    int  k;
    int  held;
    int  got_j;
    logic st_v;
    k = 0;
    held = 0;
    got_j = -1;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    for (int c = 0; c < 200 && k < N; c++) begin
      chk({tag, "_scan"}, 1'b1, (k / SP) % W, k / (SP * W), k % SP, (k == N - 1), 1'b1, 1'b0);
      st_v = (k == stall_k) && (held < stall_n);
      if (st_v) held++;
      pif.stall   = st_v;
      frame_start = (k == fs_k);
      abort       = (k == abort_k);
      step();
      frame_start = 1'b0;
      if (abort) begin
        abort = 1'b0;
        pif.stall = 1'b0;
        chk({tag, "_abort"}, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
          step();
          chk({tag, "_post_abort"}, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        end
        return;
      end
      if (!st_v) k++;
    end
    pif.stall = 1'b0;
    n_cmp++;
    if (k != N) begin
      n_bad++;
      $display("FAIL %s_scan_len: got %0d accepts, expected %0d", tag, k, N);
    end
    chk({tag, "_drain0"}, 1'b0, W - 1, H - 1, SP - 1, 1'b0, 1'b1, 1'b0);
    for (int j = 1; j <= 30 && got_j < 0; j++) begin
      pif.stall = (j <= drain_stall);
      step();
      if (frame_done === 1'b1) got_j = j;
      else chk({tag, "_drain"}, 1'b0, W - 1, H - 1, SP - 1, 1'b0, 1'b1, 1'b0);
    end
    pif.stall = 1'b0;
    n_cmp++;
    if (got_j != L + drain_stall) begin
      n_bad++;
      $display("FAIL %s_done_lat: got %0d cycles after last accept, expected %0d",
               tag, got_j, L + drain_stall);
    end
    chk_flags({tag, "_done"}, 1'b0, 1'b1, 1'b1);
    step();
    chk({tag, "_idle"}, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 0, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 0, 0, 0, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 1, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1, 0, 0, 1'b0, 1'b1, 1'b0};
    tbl[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1, 0, 1, 1'b0, 1'b1, 1'b0};
    tbl[8] = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0};
    tbl[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0};

    rst = 1'b1;
    frame_start = 1'b0;
    abort = 1'b0;
    pif.stall = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    chk("reset", 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("idle_quiet", 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    end

    for (int i = 0; i < 10; i++) begin
      frame_start = tbl[i].fs;
      abort       = tbl[i].ab;
      pif.stall   = tbl[i].st;
      step();
      chk($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ex, tbl[i].ey, tbl[i].es,
          tbl[i].el, tbl[i].eb, tbl[i].ed);
    end
    frame_start = 1'b0;
    abort = 1'b0;
    pif.stall = 1'b0;

    run_frame("base", -1, 0, 0, -1, -1);
    run_frame("scan_stall", 13, 5, 0, -1, -1);
    run_frame("drain_stall", -1, 0, 3, -1, -1);
    run_frame("restart", -1, 0, 0, 5, -1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("after_restart", 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    end
    run_frame("new_frame", -1, 0, 0, -1, -1);
    run_frame("abort", -1, 0, 0, -1, 9);
    run_frame("post_abort", -1, 0, 0, -1, -1);

    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_reset", 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
